pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the three-stage fetch/decode/execute pipeline.
- Monitors the IF_ID, ID_EX and EX_WB stage contents.
- Drives stall, bubble, flush and forwarding-select controls so that load-use hazards, taken branches and multi-cycle execute operations are handled without corrupting EX_WB.
- Sits beside the pipeline registers; purely a control block, it carries no datapath.

Parameters:
REG_AW, 5, register-address width.
MC_TIMEOUT, 16, max MC_WAIT cycles before abort (>=2).
FLUSH_CYCLES, 2, cycles IF_ID is flushed after taken branch (>=1).
CNT_W, 16, stall performance counter width.

Ports:
clock  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-low reset.
id_valid  in  1  IF_ID holds valid instruction.
id_rs1, id_rs2  in  REG_AW  decode source registers.
id_uses_rs1, id_uses_rs2  in  1  source actually read.
ex_valid, ex_wen, ex_is_load  in  1  ID_EX stage status.
ex_rd  in  REG_AW  EX destination.
wb_valid, wb_wen  in  1  EX_WB stage status.
wb_rd  in  REG_AW  WB destination.
ex_branch_taken  in  1  branch resolved taken in EX.
ex_mc_start  in  1  multi-cycle op entering EX.
ex_mc_done  in  1  multi-cycle op result ready.
if_stall, id_stall  out  1  hold PC / IF_ID.
ex_hold  out  1  hold ID_EX/EX unit, block EX_WB write.
ex_bubble  out  1  load NOP into ID_EX.
if_id_flush  out  1  invalidate IF_ID.
fwd_a, fwd_b  out  2  00 regfile, 01 from EX, 10 from WB.
mc_timeout_err  out  1  sticky timeout flag.
stall_count  out  CNT_W  saturating count of if_stall cycles.
state  out  2  00 RUN, 01 MC_WAIT, 10 FLUSH.

Behaviour:
- Reset (reset=0, async):
  - state=RUN; internal counter=0; mc_timeout_err=0; stall_count=0.
  - Every output decoded from state is 0 immediately, including when reset arrives mid-MC_WAIT or mid-FLUSH.
- Load-use hazard (LU):
  - LU = id_valid & ex_valid & ex_wen & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN (controls combinational, same cycle). Priority: branch > mc_start > LU.
  - ex_branch_taken: if_id_flush=1, ex_bubble=1. If FLUSH_CYCLES>1, next state is FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - ex_mc_start (no branch): next state is MC_WAIT with cnt=0. No stall in the start cycle.
  - LU: if_stall=id_stall=ex_bubble=1 for exactly this cycle. The bubble clears ex_valid, so there is no second stall.
  - ex_mc_done in RUN is ignored.
- MC_WAIT:
  - if_stall=id_stall=ex_hold=1; ex_bubble=0; ex_branch_taken and LU are ignored.
  - ex_mc_done=1: all three stall outputs 0 that same cycle; next state RUN.
  - Otherwise cnt++. When cnt==MC_TIMEOUT-1 without done: set mc_timeout_err (sticky until reset); next state RUN. In that cycle the stalls are still asserted.
- FLUSH:
  - if_id_flush=1, ex_bubble=1, stalls 0.
  - cnt==0: next state RUN; otherwise cnt--.
  - A branch in FLUSH is impossible because EX holds a bubble; it is ignored.
- Forwarding (combinational, every state):
  - fwd_a=01 if ex_valid & ex_wen & !ex_is_load & ex_rd!=0 & ex_rd==id_rs1.
  - Else fwd_a=10 if wb_valid & wb_wen & wb_rd!=0 & wb_rd==id_rs1.
  - Else 00.
  - EX has priority over WB. fwd_b is the same using id_rs2. Register 0 is never forwarded.
- stall_count: increments on each clock edge where if_stall=1; saturates at all-ones and never wraps.
- A zero-latency done (ex_mc_start then ex_mc_done on the next cycle) costs 0 stall cycles.

Test Plan:
1. Reset low mid-MC_WAIT (cycle 3) → state=00, if_stall=ex_hold=0 before next edge; stall_count=0, mc_timeout_err=0.
2. Load to r5 in EX, decode reads r5 via rs2 → one cycle of if_stall=id_stall=ex_bubble=1, then 0. Next cycle fwd_b=10 with wb_rd=5; stall_count=1. Repeat with rd=0 → no stall.
3. ALU writes r3 in EX and r3 in WB, decode rs1=r3 → fwd_a=01. With ex_wen=0 → fwd_a=10. With rs1=0 → fwd_a=00.
4. ex_branch_taken in RUN, FLUSH_CYCLES=2 → if_id_flush=1 for exactly 2 cycles (state 00 then 10), then RUN. Simultaneous ex_mc_start is ignored and stays in RUN.
5. ex_mc_start, ex_mc_done asserted 4 cycles later → stalls high for 3 cycles, low on the done cycle, state returns to 00.
6. ex_mc_start, ex_mc_done never asserted, MC_TIMEOUT=16 → stalls for 16 cycles, mc_timeout_err=1 persists, RUN resumes. Saturation check with CNT_W=4: 20 stall cycles → stall_count=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundles the stage-status inputs and the hazard-control outputs of
//   pipe_hazard_ctrl.
//   master : pipeline side. It drives the stage status and receives the controls.
//   slave  : hazard controller. It receives the stage status and drives the controls.
//   Stage status : id_* (IF_ID), ex_* (ID_EX), wb_* (EX_WB), plus
//                  ex_branch_taken, ex_mc_start and ex_mc_done.
//   Controls     : if_stall, id_stall, ex_hold, ex_bubble, if_id_flush,
//                  fwd_a, fwd_b, mc_timeout_err, stall_count, state.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   // IF_ID stage
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_uses_rs1;
   logic              id_uses_rs2;
   // ID_EX stage
   logic              ex_valid;
   logic              ex_wen;
   logic              ex_is_load;
   logic [REG_AW-1:0] ex_rd;
   // EX_WB stage
   logic              wb_valid;
   logic              wb_wen;
   logic [REG_AW-1:0] wb_rd;
   // EX events
   logic              ex_branch_taken;
   logic              ex_mc_start;
   logic              ex_mc_done;
   // Controls
   logic              if_stall;
   logic              id_stall;
   logic              ex_hold;
   logic              ex_bubble;
   logic              if_id_flush;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic              mc_timeout_err;
   logic [CNT_W-1:0]  stall_count;
   logic [1:0]        state;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_valid, ex_wen, ex_is_load, ex_rd,
             wb_valid, wb_wen, wb_rd,
             ex_branch_taken, ex_mc_start, ex_mc_done,
      input  if_stall, id_stall, ex_hold, ex_bubble, if_id_flush,
             fwd_a, fwd_b, mc_timeout_err, stall_count, state
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_valid, ex_wen, ex_is_load, ex_rd,
             wb_valid, wb_wen, wb_rd,
             ex_branch_taken, ex_mc_start, ex_mc_done,
      output if_stall, id_stall, ex_hold, ex_bubble, if_id_flush,
             fwd_a, fwd_b, mc_timeout_err, stall_count, state
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and sequencing controller for a three-stage fetch/decode/execute
//   pipeline. It is control only and carries no datapath.
//   It handles four cases:
//     - load-use hazards: one stall cycle plus a bubble into ID_EX
//     - taken branches: IF_ID is flushed for FLUSH_CYCLES cycles
//     - multi-cycle execute: the pipe is held until done or MC_TIMEOUT
//     - operand forwarding: EX has priority over WB, and r0 is never forwarded
//   Ports:
//     clock : pipeline clock, rising edge
//     reset : asynchronous, active-low reset
//     hz    : pipe_hazard_ctrl_if.slave (stage status in, controls out)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int MC_TIMEOUT   = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                clock,
   input  logic                reset,
   pipe_hazard_ctrl_if.slave   hz
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_MC_WAIT = 2'b01,
      ST_FLUSH   = 2'b10
   } state_e;

   // One shared counter serves both the MC_WAIT timeout and the FLUSH length.
   localparam int CNT_MAX = (MC_TIMEOUT > FLUSH_CYCLES) ? MC_TIMEOUT : FLUSH_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             lu_hazard;

   // Load-use: the decode stage reads a register that a load in EX has not yet produced.
   assign lu_hazard = hz.id_valid & hz.ex_valid & hz.ex_wen & hz.ex_is_load &
                      (hz.ex_rd != '0) &
                      ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

   // A load result is not available in EX, so it can only forward from WB.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
      if (hz.ex_valid && hz.ex_wen && !hz.ex_is_load &&
          (hz.ex_rd != '0) && (hz.ex_rd == rs))
         return 2'b01;
      else if (hz.wb_valid && hz.wb_wen && (hz.wb_rd != '0) && (hz.wb_rd == rs))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples the values that were present before the clock edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         stall_count_q <= stall_count_d;
      end
   end

   // --------------------------------------------------------------- next state
   // NOTE: every signal gets a default before the case, so no path through
   // this block can leave a value unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         ST_RUN: begin
            if (hz.ex_branch_taken) begin
               // A single flush cycle is handled entirely inside RUN.
               if (FLUSH_CYCLES > 1) begin
                  state_d = ST_FLUSH;
                  cnt_d   = CW'(FLUSH_CYCLES - 2);
               end
            end else if (hz.ex_mc_start) begin
               state_d = ST_MC_WAIT;
               cnt_d   = '0;
            end
         end
         ST_MC_WAIT: begin
            if (hz.ex_mc_done) begin
               state_d = ST_RUN;
            end else if (cnt_q == CW'(MC_TIMEOUT - 1)) begin
               state_d = ST_RUN;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = ST_RUN;
      endcase
   end

   // ----------------------------------------------------------------- outputs
   always_comb begin
      hz.if_stall    = 1'b0;
      hz.id_stall    = 1'b0;
      hz.ex_hold     = 1'b0;
      hz.ex_bubble   = 1'b0;
      hz.if_id_flush = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (hz.ex_branch_taken) begin
               hz.if_id_flush = 1'b1;
               hz.ex_bubble   = 1'b1;
            end else if (!hz.ex_mc_start && lu_hazard) begin
               // The bubble clears ex_valid next cycle, so this stall lasts one cycle.
               hz.if_stall  = 1'b1;
               hz.id_stall  = 1'b1;
               hz.ex_bubble = 1'b1;
            end
         end
         ST_MC_WAIT: begin
            // Release in the done cycle itself, so a done arriving in the
            // first wait cycle costs no stall cycles.
            hz.if_stall = !hz.ex_mc_done;
            hz.id_stall = !hz.ex_mc_done;
            hz.ex_hold  = !hz.ex_mc_done;
         end
         ST_FLUSH: begin
            hz.if_id_flush = 1'b1;
            hz.ex_bubble   = 1'b1;
         end
         default: ;
      endcase
   end

   // Saturating count of the cycles in which the front end was stalled.
   always_comb begin
      stall_count_d = stall_count_q;
      if (hz.if_stall && (stall_count_q != '1))
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   assign hz.fwd_a          = fwd_sel(hz.id_rs1);
   assign hz.fwd_b          = fwd_sel(hz.id_rs2);
   assign hz.mc_timeout_err = err_q;
   assign hz.stall_count    = stall_count_q;
   assign hz.state          = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed testbench for pipe_hazard_ctrl (MC_TIMEOUT=16, FLUSH_CYCLES=2,
//   CNT_W=4, so the stall counter saturates at 15).
//   Inputs change 1 time unit after a rising edge. Outputs are compared
//   before the next rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic clock;
   logic reset;
   int   n_total;
   int   n_bad;

   pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) hz ();

   pipe_hazard_ctrl #(
      .REG_AW      (5),
      .MC_TIMEOUT  (16),
      .FLUSH_CYCLES(2),
      .CNT_W       (4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .hz   (hz.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      hz.id_valid        = 1'b0;
      hz.id_rs1          = '0;
      hz.id_rs2          = '0;
      hz.id_uses_rs1     = 1'b0;
      hz.id_uses_rs2     = 1'b0;
      hz.ex_valid        = 1'b0;
      hz.ex_wen          = 1'b0;
      hz.ex_is_load      = 1'b0;
      hz.ex_rd           = '0;
      hz.wb_valid        = 1'b0;
      hz.wb_wen          = 1'b0;
      hz.wb_rd           = '0;
      hz.ex_branch_taken = 1'b0;
      hz.ex_mc_start     = 1'b0;
      hz.ex_mc_done      = 1'b0;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset   = 1'b0;
      clear_inputs();
      #1;
      check("rst_state",   32'(hz.state), 0);
      check("rst_scount",  32'(hz.stall_count), 0);
      check("rst_err",     32'(hz.mc_timeout_err), 0);
      check("rst_ifstall", 32'(hz.if_stall), 0);
      tick();
      tick();
      reset = 1'b1;

      // ---- 1: reset arriving in the third MC_WAIT cycle
      hz.ex_mc_start = 1'b1;
      #1;
      check("t1_start_nostall", 32'(hz.if_stall), 0);
      tick();
      hz.ex_mc_start = 1'b0;
      tick();
      tick();
      check("t1_in_wait",  32'(hz.state), 1);
      check("t1_stalling", 32'(hz.if_stall), 1);
      reset = 1'b0;
      #1;
      check("t1_rst_state",  32'(hz.state), 0);
      check("t1_rst_ifstl",  32'(hz.if_stall), 0);
      check("t1_rst_hold",   32'(hz.ex_hold), 0);
      check("t1_rst_scount", 32'(hz.stall_count), 0);
      check("t1_rst_err",    32'(hz.mc_timeout_err), 0);
      tick();
      reset = 1'b1;
      #1;
      check("t1_after_rst", 32'(hz.state), 0);

      // ---- 2: load-use hazard on rs2
      hz.ex_valid = 1'b1; hz.ex_wen = 1'b1; hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5;
      hz.id_valid = 1'b1; hz.id_uses_rs1 = 1'b1; hz.id_rs1 = 5'd7;
      hz.id_uses_rs2 = 1'b1; hz.id_rs2 = 5'd5;
      #1;
      check("t2_lu_ifstall", 32'(hz.if_stall), 1);
      check("t2_lu_idstall", 32'(hz.id_stall), 1);
      check("t2_lu_bubble",  32'(hz.ex_bubble), 1);
      check("t2_lu_nofwd",   32'(hz.fwd_b), 0);
      tick();
      // The bubble has emptied EX, and the load is now in WB.
      hz.ex_valid = 1'b0;
      hz.wb_valid = 1'b1; hz.wb_wen = 1'b1; hz.wb_rd = 5'd5;
      #1;
      check("t2_ifstall_off", 32'(hz.if_stall), 0);
      check("t2_bubble_off",  32'(hz.ex_bubble), 0);
      check("t2_fwd_b_wb",    32'(hz.fwd_b), 2);
      check("t2_scount",      32'(hz.stall_count), 1);
      tick();
      hz.wb_valid = 1'b0;
      hz.ex_valid = 1'b1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0;
      #1;
      check("t2_r0_nostall", 32'(hz.if_stall), 0);
      check("t2_r0_nofwd",   32'(hz.fwd_b), 0);
      tick();
      clear_inputs();

      // ---- 3: forwarding priority
      hz.ex_valid = 1'b1; hz.ex_wen = 1'b1; hz.ex_rd = 5'd3;
      hz.wb_valid = 1'b1; hz.wb_wen = 1'b1; hz.wb_rd = 5'd3;
      hz.id_valid = 1'b1; hz.id_rs1 = 5'd3; hz.id_rs2 = 5'd3;
      #1;
      check("t3_fwd_a_ex", 32'(hz.fwd_a), 1);
      check("t3_fwd_b_ex", 32'(hz.fwd_b), 1);
      hz.ex_wen = 1'b0;
      #1;
      check("t3_fwd_a_wb", 32'(hz.fwd_a), 2);
      hz.ex_wen = 1'b1; hz.ex_rd = 5'd0; hz.wb_rd = 5'd0; hz.id_rs1 = 5'd0;
      #1;
      check("t3_fwd_a_r0", 32'(hz.fwd_a), 0);
      tick();
      clear_inputs();

      // ---- 4: taken branch with a simultaneous mc_start
      hz.ex_branch_taken = 1'b1; hz.ex_mc_start = 1'b1;
      #1;
      check("t4_flush0",   32'(hz.if_id_flush), 1);
      check("t4_bubble0",  32'(hz.ex_bubble), 1);
      check("t4_state0",   32'(hz.state), 0);
      check("t4_nostall0", 32'(hz.if_stall), 0);
      tick();
      clear_inputs();
      #1;
      check("t4_state1",  32'(hz.state), 2);
      check("t4_flush1",  32'(hz.if_id_flush), 1);
      check("t4_bubble1", 32'(hz.ex_bubble), 1);
      tick();
      check("t4_state2", 32'(hz.state), 0);
      check("t4_flush2", 32'(hz.if_id_flush), 0);

      // ---- 5: multi-cycle op, done 4 cycles after start
      hz.ex_mc_start = 1'b1;
      #1;
      check("t5_start_nostall", 32'(hz.if_stall), 0);
      tick();
      hz.ex_mc_start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         // A branch or load-use condition must not disturb the wait.
         if (i == 2) begin
            hz.ex_branch_taken = 1'b1;
            hz.ex_valid = 1'b1; hz.ex_wen = 1'b1; hz.ex_is_load = 1'b1; hz.ex_rd = 5'd9;
            hz.id_valid = 1'b1; hz.id_uses_rs1 = 1'b1; hz.id_rs1 = 5'd9;
         end
         #1;
         check($sformatf("t5_ifstall_c%0d", i), 32'(hz.if_stall), 1);
         check($sformatf("t5_hold_c%0d", i),    32'(hz.ex_hold), 1);
         check($sformatf("t5_bubble_c%0d", i),  32'(hz.ex_bubble), 0);
         check($sformatf("t5_flush_c%0d", i),   32'(hz.if_id_flush), 0);
         tick();
         clear_inputs();
      end
      hz.ex_mc_done = 1'b1;
      #1;
      check("t5_done_ifstall", 32'(hz.if_stall), 0);
      check("t5_done_idstall", 32'(hz.id_stall), 0);
      check("t5_done_hold",    32'(hz.ex_hold), 0);
      tick();
      hz.ex_mc_done = 1'b0;
      #1;
      check("t5_back_run", 32'(hz.state), 0);
      check("t5_scount",   32'(hz.stall_count), 4);

      // Done in the first wait cycle costs no stall cycles.
      hz.ex_mc_start = 1'b1;
      tick();
      hz.ex_mc_start = 1'b0; hz.ex_mc_done = 1'b1;
      #1;
      check("t5z_nostall", 32'(hz.if_stall), 0);
      tick();
      hz.ex_mc_done = 1'b0;
      #1;
      check("t5z_state",  32'(hz.state), 0);
      check("t5z_scount", 32'(hz.stall_count), 4);

      // ---- 6: timeout with no done, and the counter saturating
      hz.ex_mc_start = 1'b1;
      tick();
      hz.ex_mc_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t6_stall_c%0d", i), 32'(hz.if_stall), 1);
         check($sformatf("t6_err_c%0d", i),   32'(hz.mc_timeout_err), 0);
         tick();
      end
      check("t6_state",  32'(hz.state), 0);
      check("t6_err",    32'(hz.mc_timeout_err), 1);
      check("t6_nostl",  32'(hz.if_stall), 0);
      check("t6_scount", 32'(hz.stall_count), 15);
      tick();
      tick();
      check("t6_err_sticky", 32'(hz.mc_timeout_err), 1);
      // One more load-use stall must leave the saturated count at 15.
      hz.ex_valid = 1'b1; hz.ex_wen = 1'b1; hz.ex_is_load = 1'b1; hz.ex_rd = 5'd4;
      hz.id_valid = 1'b1; hz.id_uses_rs1 = 1'b1; hz.id_rs1 = 5'd4;
      #1;
      check("t6_lu_stall", 32'(hz.if_stall), 1);
      tick();
      clear_inputs();
      #1;
      check("t6_sat", 32'(hz.stall_count), 15);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
